// File: rtl/fc_feature_buffer.sv
// Ping-pong flatten buffer between the last conv/pool stage and the FC layer.
// Collects N_FEAT activations per frame, replays each frame as LANES-wide beats.
module fc_feature_buffer #(
    parameter int N_FEAT = 64,
    parameter int LANES  = 4,
    parameter int DW     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    input  logic                in_abort,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [LANES*DW-1:0] out_data,
    output logic                out_last,
    output logic [15:0]         frame_cnt
);

    localparam int BEATS = N_FEAT / LANES;
    localparam int AW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW-1:0] LAST_IDX  = AW'(N_FEAT - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] mem [2][N_FEAT];
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic [AW-1:0] wr_cnt_q;
    logic [BW-1:0] beat_q;
    logic [BW-1:0] beat_d;
    logic [15:0]   frame_cnt_q;

    logic accept;
    logic wr_en;
    logic wr_done;
    logic rd_done;

    // A bank is writable only while empty, so writer and reader never share one.
    assign in_ready  = !rst && !full_q[wr_bank_q];
    assign accept    = in_valid && in_ready;
    assign wr_en     = accept && !in_abort;
    assign wr_done   = wr_en && (wr_cnt_q == LAST_IDX);
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank_q][wr_cnt_q] <= in_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        rd_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && out_ready) begin
                    state_d = STREAM;
                    beat_d  = '0;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                beat_d    = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    out_last = 1'b1;
                    rd_done  = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // Free and fill always target different banks, so both may land together.
    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (out_valid) begin
                out_data[k*DW +: DW] =
                    mem[rd_bank_q][AW'(int'(beat_q) * LANES + k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            full_q  <= full_d;
            if (in_abort) begin
                wr_cnt_q <= '0;
            end else if (wr_done) begin
                wr_cnt_q  <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (rd_done) begin
                rd_bank_q   <= ~rd_bank_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

endmodule
